// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding,
// counter sizing and parameter legality check.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit cfg_ok(input int dw, input int cpb, input int par, input int stop);
    return (dw >= 1) && (cpb >= 2) && (par == 0 || par == 1) && (stop == 1 || stop == 2);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: free-running modulo-CLKS_PER_BIT counter with a
// synchronous clear; tick marks the last cycle of each bit period.
module baud_tick_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Baud counter: held at zero while cleared, wraps at the bit boundary.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST) & ~i_clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed async serial transmitter: pops one word per frame and sends
// start, data LSB-first, optional even parity and stop bit(s).
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = cnt_w(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  if (!cfg_ok(DATA_WIDTH, CLKS_PER_BIT, PARITY_EN, STOP_BITS)) begin : g_cfg_err
    $error("fifo_uart_tx: illegal parameter combination");
  end

  state_e                r_state;
  state_e                w_state_next;
  logic                  w_pop;
  logic                  w_tick;
  logic                  w_baud_clr;
  logic                  w_last_stop;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_stop_cnt;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_busy;

  assign w_baud_clr  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_shifted   = r_shreg >> 1;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_baud_clr),
    .o_tick  (w_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and pop decode; pop only ever leaves IDLE.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pop = enable & ~empty & rst_n;
        if (w_pop) w_state_next = ST_LOAD;
        else       w_state_next = ST_IDLE;
      end
      ST_LOAD:  w_state_next = ST_START;
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
        else        w_state_next = ST_START;
      end
      ST_DATA: begin
        if (w_tick && (r_bit_cnt == LAST_BIT)) w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        else                                   w_state_next = ST_DATA;
      end
      ST_PARITY: begin
        if (w_tick) w_state_next = ST_STOP;
        else        w_state_next = ST_PARITY;
      end
      ST_STOP: begin
        if (w_tick && w_last_stop) w_state_next = ST_IDLE;
        else                       w_state_next = ST_STOP;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: tx is loaded with the level of the bit about to start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
      case (r_state)
        ST_LOAD: begin
          r_shreg    <= data_in;
          r_parity   <= ^data_in;
          r_bit_cnt  <= '0;
          r_stop_cnt <= 1'b0;
          r_tx       <= 1'b0;
        end
        ST_START: begin
          if (w_tick) r_tx <= r_shreg[0];
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_tx <= (PARITY_EN != 0) ? r_parity : 1'b1;
            end else begin
              r_shreg   <= w_shifted;
              r_tx      <= w_shifted[0];
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) r_tx <= 1'b1;
        end
        ST_STOP: begin
          if (w_tick && !w_last_stop) r_stop_cnt <= 1'b1;
        end
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign pop        = w_pop;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = (r_state == ST_STOP) & w_tick & w_last_stop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: two transmitters (no parity / even parity) fed by
// queue-based FIFO models, checked cycle by cycle against expected waveforms.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b1, em_a = 1'b1, pop_a, tx_a, busy_a, fd_a;
  logic en_b = 1'b1, em_b = 1'b1, pop_b, tx_b, busy_b, fd_b;
  logic [DW-1:0] d_a = '0, d_b = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [3:0]    exp_q[$];
  logic [3:0]    s_a, s_b;
  logic [DW-1:0] w1, w2;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .empty(em_a), .data_in(d_a),
    .pop(pop_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
  );

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .empty(em_b), .data_in(d_b),
    .pop(pop_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample outputs at negedge, then model the FIFO read after the edge.
  task automatic step();
    @(negedge clk);
    s_a = {pop_a, busy_a, tx_a, fd_a};
    s_b = {pop_b, busy_b, tx_b, fd_b};
    chk("underflow", 32'({pop_a & em_a, pop_b & em_b}), 32'd0);
    @(posedge clk);
    #1;
    if (s_a[3] && qa.size() > 0) d_a = qa.pop_front();
    if (s_b[3] && qb.size() > 0) d_b = qb.pop_front();
    em_a = (qa.size() == 0);
    em_b = (qb.size() == 0);
  endtask

  // Expected {pop,busy,tx,frame_done} per cycle for one word: IDLE, LOAD, then the frame.
  function automatic void add_frame(input logic [DW-1:0] w, input bit par);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (par) bits.push_back(^w);
    bits.push_back(1'b1);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0110);
    for (int j = 0; j < bits.size(); j++)
      for (int k = 0; k < CPB; k++)
        exp_q.push_back({1'b0, 1'b1, bits[j], (j == bits.size() - 1) && (k == CPB - 1)});
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0010);
  endfunction

  task automatic run_exp(input bit sel_b, input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s_c%0d", tag, exp_idx), 32'(sel_b ? s_b : s_a), 32'(exp_q[exp_idx]));
      exp_idx++;
    end
  endtask

  task automatic new_exp();
    exp_q.delete();
    exp_idx = 0;
  endtask

  initial begin
    step();
    qa.push_back(8'hA5);
    em_a = 1'b0;
    repeat (2) begin
      step();
      chk("rst_pop", 32'(s_a[3]), 32'd0);
      chk("rst_tx", 32'(s_a[1]), 32'd1);
      chk("rst_busy", 32'(s_a[2]), 32'd0);
    end
    rst_n = 1'b1;

    new_exp(); add_frame(8'hA5, 1'b0); add_idle(4);
    run_exp(1'b0, "a5", exp_q.size());

    qb.push_back(8'h07); qb.push_back(8'h03); em_b = 1'b0;
    new_exp(); add_frame(8'h07, 1'b1); add_frame(8'h03, 1'b1); add_idle(4);
    run_exp(1'b1, "par", exp_q.size());

    qa.push_back(8'h11); qa.push_back(8'h22); qa.push_back(8'h33); em_a = 1'b0;
    new_exp(); add_frame(8'h11, 1'b0); add_frame(8'h22, 1'b0); add_frame(8'h33, 1'b0); add_idle(4);
    run_exp(1'b0, "three", exp_q.size());

    repeat (100) begin
      step();
      chk("empty_pop", 32'(s_a[3]), 32'd0);
      chk("empty_tx", 32'(s_a[1]), 32'd1);
    end

    w1 = 8'($urandom); w2 = 8'($urandom);
    qa.push_back(w1); qa.push_back(w2); em_a = 1'b0;
    new_exp(); add_frame(w1, 1'b0); add_idle(8);
    run_exp(1'b0, "en", 15);
    en_a = 1'b0;
    run_exp(1'b0, "en_off", exp_q.size() - exp_idx);
    chk("en_left", 32'(qa.size()), 32'd1);
    qa.delete(); em_a = 1'b1; en_a = 1'b1;

    w1 = 8'($urandom); w2 = ~w1;
    qa.push_back(w1); qa.push_back(w2); em_a = 1'b0;
    new_exp(); add_frame(w1, 1'b0);
    run_exp(1'b0, "pre_rst", 19);
    rst_n = 1'b0;
    step();
    chk("mrst_pop0", 32'(s_a[3]), 32'd0);
    step();
    chk("mrst_tx", 32'(s_a[1]), 32'd1);
    chk("mrst_busy", 32'(s_a[2]), 32'd0);
    chk("mrst_pop1", 32'(s_a[3]), 32'd0);
    rst_n = 1'b1;
    new_exp(); add_frame(w2, 1'b0); add_idle(4);
    run_exp(1'b0, "post_rst", exp_q.size());
    chk("post_rst_q", 32'(qa.size()), 32'd0);

    for (int r = 0; r < 4; r++) begin
      new_exp();
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
        w1 = 8'($urandom);
        if (r % 2 == 1) qb.push_back(w1);
        else            qa.push_back(w1);
        add_frame(w1, r % 2 == 1);
      end
      add_idle(3);
      em_a = (qa.size() == 0);
      em_b = (qb.size() == 0);
      run_exp(r % 2 == 1, $sformatf("rnd%0d", r), exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
